// File: rtl/mp_adder_arbiter.sv
// Round-robin arbiter and sequencer sharing one multi-precision adder between NUM_REQ
// clients: one job in flight, operands held stable, watchdog abort on a missing done.
module mp_adder_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = 1024,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                               iClk,
  input  logic                               iRst,
  input  logic [NUM_REQ-1:0]                 iReqValid,
  output logic [NUM_REQ-1:0]                 oReqReady,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   iReqOpA,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   iReqOpB,
  input  logic [NUM_REQ-1:0]                 iReqSub,
  output logic                               oAddStart,
  output logic                               oAddSub,
  output logic [OPERAND_WIDTH-1:0]           oAddOpA,
  output logic [OPERAND_WIDTH-1:0]           oAddOpB,
  input  logic [OPERAND_WIDTH:0]             iAddRes,
  input  logic                               iAddDone,
  output logic                               oRspValid,
  input  logic                               iRspReady,
  output logic [ID_W-1:0]                    oRspId,
  output logic [OPERAND_WIDTH:0]             oRspRes,
  output logic                               oRspErr,
  output logic                               oBusy
);

  // Handshakes: a transfer happens in the cycle where valid and ready are both high; the
  // source holds valid and payload stable until then. oReqReady is combinational in IDLE.

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

  state_t                   state_q;
  logic [ID_W-1:0]          ptr_q, ptr_d, id_q, grant_id;
  logic                     grant_found;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] op_a_q, op_b_q;
  logic [OPERAND_WIDTH:0]   res_q;
  logic                     sub_q, start_q, rsp_valid_q, err_q, busy_q;
  logic [NUM_REQ-1:0]       ready;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && iReqValid[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == ST_IDLE && !iRst && grant_found) ready[grant_id] = 1'b1;
  end

  assign ptr_d = wrap_add(grant_id, 1);
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            op_a_q  <= iReqOpA[int'(grant_id)*OPERAND_WIDTH +: OPERAND_WIDTH];
            op_b_q  <= iReqOpB[int'(grant_id)*OPERAND_WIDTH +: OPERAND_WIDTH];
            sub_q   <= iReqSub[grant_id];
            id_q    <= grant_id;
            ptr_q   <= ptr_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // A real done wins over an abort landing in the same cycle.
          if (iAddDone) begin
            res_q       <= iAddRes;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_d == CNT_LAST) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (iRspReady) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oReqReady = ready;
  assign oAddStart = start_q;
  assign oAddSub   = sub_q;
  assign oAddOpA   = op_a_q;
  assign oAddOpB   = op_b_q;
  assign oRspValid = rsp_valid_q;
  assign oRspId    = id_q;
  assign oRspRes   = res_q;
  assign oRspErr   = err_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Bench for mp_adder_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with hand-computed grant orders, latencies and results.
module tb_mp_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 1024;
  localparam int TO = 64;
  localparam int IW = 2;
  localparam int RW = W + 1;

  logic                iClk, iRst;
  logic [N-1:0]        iReqValid, oReqReady, iReqSub;
  logic [N*W-1:0]      iReqOpA, iReqOpB;
  logic                oAddStart, oAddSub, iAddDone, oRspValid, iRspReady, oRspErr, oBusy;
  logic [W-1:0]        oAddOpA, oAddOpB;
  logic [RW-1:0]       iAddRes, oRspRes;
  logic [IW-1:0]       oRspId;

  mp_adder_arbiter #(.NUM_REQ(N), .OPERAND_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqOpA(iReqOpA), .iReqOpB(iReqOpB), .iReqSub(iReqSub),
    .oAddStart(oAddStart), .oAddSub(oAddSub), .oAddOpA(oAddOpA), .oAddOpB(oAddOpB),
    .iAddRes(iAddRes), .iAddDone(iAddDone), .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspId(oRspId), .oRspRes(oRspRes), .oRspErr(oRspErr), .oBusy(oBusy)
  );

  // ---------------- clock ----------------
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual carry=%b low=%h, required carry=%b low=%h",
                  name, act[RW-1], act[127:0], exp[RW-1], exp[127:0]);
  endtask

  // DUT observation logs
  int            grant_log[$], grant_cyc[$], start_cyc[$], rise_cyc[$], hs_cyc[$];
  int            rsp_id_log[$], rsp_err_log[$];
  logic [RW-1:0] rsp_res_log[$];
  logic [N-1:0]  last_ready;
  logic          prv_rv;
  int            cyc = 0;

  // Reference model state
  bit            m_sync = 0, m_act = 0, m_pend = 0;
  int            m_ptr = 0, m_id = 0, m_acc = 0;
  logic [W-1:0]  m_a, m_b;
  logic          m_sub, m_err;
  logic [RW-1:0] m_res;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int qi(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  function automatic logic [RW-1:0] qres(input int k);
    if (k < rsp_res_log.size()) return rsp_res_log[k];
    return {RW{1'b1}};
  endfunction

  // ---------------- compare process ----------------
  logic [N-1:0] e_ready;
  int           g;

  always @(negedge iClk) begin
    cyc++;
    last_ready = oReqReady;
    for (int i = 0; i < N; i++)
      if (oReqReady[i] === 1'b1) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
    if (oAddStart === 1'b1) start_cyc.push_back(cyc);
    if (oRspValid === 1'b1 && prv_rv !== 1'b1) rise_cyc.push_back(cyc);
    prv_rv = oRspValid;
    if (oRspValid === 1'b1 && iRspReady && !iRst) begin
      hs_cyc.push_back(cyc);
      rsp_id_log.push_back(int'(oRspId));
      rsp_err_log.push_back(int'(oRspErr));
      rsp_res_log.push_back(oRspRes);
    end

    if (iRst) begin
      m_sync = 1; m_act = 0; m_pend = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_sub = 1'b0;
    end else if (m_sync) begin
      g = m_act ? -1 : rr_pick(m_ptr, iReqValid);
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      chk("cyc_ready", RW'(oReqReady), RW'(e_ready));
      chk("cyc_busy", RW'(oBusy), RW'(m_act));
      chk("cyc_start", RW'(oAddStart), RW'(m_act && cyc == m_acc + 1));
      chk("cyc_rsp_valid", RW'(oRspValid), RW'(m_pend));
      chk("cyc_op_a", RW'(oAddOpA), RW'(m_a));
      chk("cyc_op_b", RW'(oAddOpB), RW'(m_b));
      chk("cyc_sub", RW'(oAddSub), RW'(m_sub));
      if (m_pend) begin
        chk("cyc_rsp_id", RW'(oRspId), RW'(m_id));
        chk("cyc_rsp_res", oRspRes, m_res);
        chk("cyc_rsp_err", RW'(oRspErr), RW'(m_err));
      end
      // advance the model by one cycle
      if (g >= 0) begin
        m_act = 1; m_id = g; m_acc = cyc; m_ptr = (g + 1) % N;
        m_a = iReqOpA[g*W +: W]; m_b = iReqOpB[g*W +: W]; m_sub = iReqSub[g];
      end else if (m_act && !m_pend && cyc > m_acc + 1) begin
        if (iAddDone) begin
          m_pend = 1; m_res = iAddRes; m_err = 1'b0;
        end else if (cyc - (m_acc + 1) == TO - 1) begin
          m_pend = 1; m_res = '0; m_err = 1'b1;
        end
      end else if (m_pend && iRspReady) begin
        m_act = 0; m_pend = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [N-1:0]  hold_mask;
  int            add_lat, add_cnt;
  logic [RW-1:0] add_res;
  bit            inject_done;

  // Advance one cycle: retire accepted one-shot requests and run the adder stand-in.
  task automatic tick();
    @(posedge iClk); #1;
    iReqValid = (iReqValid & ~(last_ready & ~hold_mask)) | hold_mask;
    iAddDone = 1'b0;
    if (inject_done) begin iAddDone = 1'b1; iAddRes = {RW{1'b1}}; inject_done = 0; end
    if (add_cnt > 0) begin
      add_cnt--;
      if (add_cnt == 0) begin iAddDone = 1'b1; iAddRes = add_res; end
    end
    if (oAddStart === 1'b1 && add_lat > 0) begin
      add_cnt = add_lat;
      add_res = oAddSub ? {1'b0, oAddOpA - oAddOpB} : ({1'b0, oAddOpA} + {1'b0, oAddOpB});
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return grant_log.size();
      1: return start_cyc.size();
      2: return rise_cyc.size();
      default: return hs_cyc.size();
    endcase
  endfunction

  task automatic wait_n(input string name, input int which, input int target, input int budget);
    int k;
    k = 0;
    while (qsize(which) < target && k < budget) begin tick(); k++; end
    chk({name, "_seen"}, RW'(qsize(which) >= target), RW'(1));
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge iClk);
    chk({tag, "_ready"}, RW'(oReqReady), '0);
    chk({tag, "_start"}, RW'(oAddStart), '0);
    chk({tag, "_sub"}, RW'(oAddSub), '0);
    chk({tag, "_op_a"}, RW'(oAddOpA), '0);
    chk({tag, "_op_b"}, RW'(oAddOpB), '0);
    chk({tag, "_rsp_valid"}, RW'(oRspValid), '0);
    chk({tag, "_rsp_id"}, RW'(oRspId), '0);
    chk({tag, "_rsp_res"}, oRspRes, '0);
    chk({tag, "_rsp_err"}, RW'(oRspErr), '0);
    chk({tag, "_busy"}, RW'(oBusy), '0);
  endtask

  // ---------------- directed scenarios ----------------
  int            g0, s0, r0, h0;
  logic [RW-1:0] e_res;
  int            exp_rr[8];

  initial begin
    iRst = 1'b1; iReqValid = '0; iReqOpA = '0; iReqOpB = '0; iReqSub = '0;
    iAddRes = '0; iAddDone = 1'b0; iRspReady = 1'b1;
    hold_mask = '0; add_lat = 0; add_cnt = 0; add_res = '0; inject_done = 0;
    tick(); tick();
    iRst = 1'b0;
    check_idle_zero("reset");

    // Single add: requester 2, 1 + (2^1024-1), adder latency 3
    g0 = grant_log.size(); s0 = start_cyc.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
    add_lat = 3;
    iReqOpA[2*W +: W] = W'(1); iReqOpB[2*W +: W] = {W{1'b1}}; iReqSub[2] = 1'b0;
    iReqValid[2] = 1'b1;
    wait_n("add_hs", 3, h0 + 1, 20);
    chk("add_grant", RW'(qi(grant_log, g0)), RW'(2));
    chk("add_start_lat", RW'(qi(start_cyc, s0) - qi(grant_cyc, g0)), RW'(1));
    chk("add_rsp_lat", RW'(qi(rise_cyc, r0) - qi(start_cyc, s0)), RW'(4));
    chk("add_id", RW'(qi(rsp_id_log, h0)), RW'(2));
    e_res = '0; e_res[W] = 1'b1;
    chk("add_res", qres(h0), e_res);
    chk("add_err", RW'(qi(rsp_err_log, h0)), RW'(0));

    // Subtract from requester 0 under response backpressure, requester 1 queued behind
    g0 = grant_log.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
    iRspReady = 1'b0; add_lat = 5;
    iReqOpA[0*W +: W] = W'(5); iReqOpB[0*W +: W] = W'(3); iReqSub[0] = 1'b1;
    iReqOpA[1*W +: W] = W'(7); iReqOpB[1*W +: W] = W'(9); iReqSub[1] = 1'b0;
    iReqValid[0] = 1'b1; iReqValid[1] = 1'b1;
    wait_n("bp_rise", 2, r0 + 1, 30);
    repeat (10) tick();
    chk("bp_no_grant", RW'(grant_log.size()), RW'(g0 + 1));
    iRspReady = 1'b1;
    wait_n("bp_hs", 3, h0 + 1, 5);
    wait_n("bp_resume", 0, g0 + 2, 5);
    chk("sub_grant", RW'(qi(grant_log, g0)), RW'(0));
    chk("sub_id", RW'(qi(rsp_id_log, h0)), RW'(0));
    chk("sub_res", qres(h0), RW'(2));
    chk("bp_next_grant", RW'(qi(grant_log, g0 + 1)), RW'(1));
    chk("bp_resume_lat", RW'(qi(grant_cyc, g0 + 1) - qi(hs_cyc, h0)), RW'(1));
    wait_n("add2_hs", 3, h0 + 2, 20);
    chk("add2_res", qres(h0 + 1), RW'(16));

    // Round-robin from reset: all four continuously valid, then only 1 and 3
    iRst = 1'b1; iReqValid = '0; add_cnt = 0;
    tick();
    iRst = 1'b0;
    g0 = grant_log.size(); h0 = hs_cyc.size();
    for (int i = 0; i < N; i++) begin
      iReqOpA[i*W +: W] = W'($urandom); iReqOpB[i*W +: W] = W'($urandom);
      iReqSub[i] = 1'($urandom_range(0, 1));
    end
    add_lat = 2; hold_mask = 4'hF; iReqValid = 4'hF;
    wait_n("rr_first5", 0, g0 + 5, 60);
    hold_mask = 4'b1010; iReqValid = 4'b1010;
    wait_n("rr_next3", 0, g0 + 8, 60);
    exp_rr = '{0, 1, 2, 3, 0, 1, 3, 1};
    for (int k = 0; k < 8; k++) chk($sformatf("rr_grant%0d", k), RW'(qi(grant_log, g0 + k)), RW'(exp_rr[k]));
    hold_mask = '0; iReqValid = '0;
    wait_n("rr_drain", 3, h0 + 8, 40);

    // Watchdog: adder never answers; a late done during RESP must be ignored
    s0 = start_cyc.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
    add_lat = 0; iRspReady = 1'b0;
    iReqOpA[1*W +: W] = W'(32'h1234_5678); iReqOpB[1*W +: W] = W'(32'h0bad_f00d); iReqSub[1] = 1'b1;
    iReqValid[1] = 1'b1;
    wait_n("wd_rise", 2, r0 + 1, 100);
    inject_done = 1;
    repeat (3) tick();
    iRspReady = 1'b1;
    wait_n("wd_hs", 3, h0 + 1, 5);
    chk("wd_lat", RW'(qi(rise_cyc, r0) - qi(start_cyc, s0)), RW'(64));
    chk("wd_id", RW'(qi(rsp_id_log, h0)), RW'(1));
    chk("wd_err", RW'(qi(rsp_err_log, h0)), RW'(1));
    chk("wd_res", qres(h0), '0);

    // Reset during WAIT, then requesters 3 and 0 together: 0 wins
    s0 = start_cyc.size();
    iReqOpA[2*W +: W] = W'(32'hdead_beef); iReqOpB[2*W +: W] = W'(32'h0000_0042); iReqSub[2] = 1'b1;
    iReqValid[2] = 1'b1;
    wait_n("mr_start", 1, s0 + 1, 10);
    repeat (2) tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check_idle_zero("mid_reset");
    g0 = grant_log.size(); h0 = hs_cyc.size();
    add_lat = 1;
    iReqOpA[3*W +: W] = W'(11); iReqOpB[3*W +: W] = W'(22); iReqSub[3] = 1'b0;
    iReqOpA[0*W +: W] = W'(40); iReqOpB[0*W +: W] = W'(1);  iReqSub[0] = 1'b1;
    iReqValid[3] = 1'b1; iReqValid[0] = 1'b1;
    wait_n("mr_grants", 0, g0 + 2, 20);
    wait_n("mr_hs", 3, h0 + 2, 20);
    chk("mr_first", RW'(qi(grant_log, g0)), RW'(0));
    chk("mr_second", RW'(qi(grant_log, g0 + 1)), RW'(3));
    chk("mr_res0", qres(h0), RW'(39));
    chk("mr_res3", qres(h0 + 1), RW'(33));

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
